// File: rtl/wb_port_arbiter_if.sv
// Requester-side result handshakes and the shared writeback/broadcast port of wb_port_arbiter.
interface wb_port_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int PD_W   = 7,
    parameter int DATA_W = 32
);
    localparam int SRC_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*PD_W-1:0]   req_pd;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic                    wb_en;
    logic [PD_W-1:0]         wb_pd;
    logic [DATA_W-1:0]       wb_data;
    logic [SRC_W-1:0]        wb_src;

    modport slave (
        input  req_valid, req_pd, req_data,
        output req_ready, wb_en, wb_pd, wb_data, wb_src
    );

    modport master (
        output req_valid, req_pd, req_data,
        input  req_ready, wb_en, wb_pd, wb_data, wb_src
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin writeback arbiter: per-requester result FIFOs drained one per cycle onto a
// registered PRF write / wakeup broadcast port; results tagged x0 are never broadcast.
module wb_port_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DEPTH  = 2,
    parameter int PD_W   = 7,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    wb_port_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(N_REQ);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PD_W-1:0]   r_mem_pd   [N_REQ][DEPTH];
    logic [DATA_W-1:0] r_mem_data [N_REQ][DEPTH];
    logic [PTR_W-1:0]  r_wptr     [N_REQ];
    logic [PTR_W-1:0]  r_rptr     [N_REQ];
    logic [CNT_W-1:0]  r_count    [N_REQ];
    logic [SRC_W-1:0]  r_rr_ptr;
    logic              r_wb_en;
    logic [PD_W-1:0]   r_wb_pd;
    logic [DATA_W-1:0] r_wb_data;
    logic [SRC_W-1:0]  r_wb_src;

    logic [N_REQ-1:0]  w_ready;
    logic [N_REQ-1:0]  w_push;
    logic [N_REQ-1:0]  w_pop;
    logic              w_win_valid;
    logic [SRC_W-1:0]  w_win_idx;
    logic [SRC_W-1:0]  w_cand;
    logic [SRC_W-1:0]  w_rr_next;
    logic [PD_W-1:0]   w_head_pd;
    logic [DATA_W-1:0] w_head_data;

    // Ready looks only at occupancy, never at this cycle's grant.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_ready[i] = !reset && !flush && (r_count[i] < CNT_W'(DEPTH));
            w_push[i]  = bus.req_valid[i] && w_ready[i];
        end
    end

    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = SRC_W'((int'(r_rr_ptr) + k) % N_REQ);
            if (!w_win_valid && (r_count[w_cand] != '0)) begin
                w_win_valid = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_pop[i] = w_win_valid && !flush && (w_win_idx == SRC_W'(i));
        end
    end

    assign w_head_pd   = r_mem_pd[w_win_idx][r_rptr[w_win_idx]];
    assign w_head_data = r_mem_data[w_win_idx][r_rptr[w_win_idx]];
    assign w_rr_next   = (w_win_idx == SRC_W'(N_REQ - 1)) ? '0 : w_win_idx + SRC_W'(1);

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (w_push[i]) begin
                r_mem_pd[i][r_wptr[i]]   <= bus.req_pd[i*PD_W +: PD_W];
                r_mem_data[i][r_wptr[i]] <= bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Stage boundary: FIFO heads -> registered writeback port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_wptr[i]  <= '0;
                r_rptr[i]  <= '0;
                r_count[i] <= '0;
            end
            r_rr_ptr  <= '0;
            r_wb_en   <= 1'b0;
            r_wb_pd   <= '0;
            r_wb_data <= '0;
            r_wb_src  <= '0;
        end else if (flush) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_wptr[i]  <= '0;
                r_rptr[i]  <= '0;
                r_count[i] <= '0;
            end
            r_rr_ptr <= '0;
            r_wb_en  <= 1'b0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_push[i]) begin
                    r_wptr[i] <= r_wptr[i] + PTR_W'(1);
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= r_rptr[i] + PTR_W'(1);
                end
                r_count[i] <= r_count[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
            end
            // An x0 result still takes its slot but is never written or broadcast.
            r_wb_en <= w_win_valid && (w_head_pd != '0);
            if (w_win_valid) begin
                r_rr_ptr  <= w_rr_next;
                r_wb_pd   <= w_head_pd;
                r_wb_data <= w_head_data;
                r_wb_src  <= w_win_idx;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.wb_en     = r_wb_en;
    assign bus.wb_pd     = r_wb_pd;
    assign bus.wb_data   = r_wb_data;
    assign bus.wb_src    = r_wb_src;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model feeding a scoreboard, a per-cycle
// monitor, directed scenarios and a randomized phase.
module tb_wb_port_arbiter;
    localparam int N_REQ  = 4;
    localparam int DEPTH  = 2;
    localparam int PD_W   = 7;
    localparam int DATA_W = 32;
    localparam int SRC_W  = $clog2(N_REQ);

    typedef struct packed {
        logic [PD_W-1:0]   pd;
        logic [DATA_W-1:0] data;
        logic [SRC_W-1:0]  src;
    } wb_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   checks   = 0;
    int   failures = 0;

    wb_port_arbiter_if #(.N_REQ(N_REQ), .PD_W(PD_W), .DATA_W(DATA_W)) bus ();

    wb_port_arbiter #(.N_REQ(N_REQ), .DEPTH(DEPTH), .PD_W(PD_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per requester plus a round-robin start index.
    wb_t              mq [N_REQ][$];
    wb_t              sb [$];
    int               rr_m = 0;
    logic [N_REQ-1:0] m_acc;
    int               m_w;
    int               m_j;
    wb_t              m_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int i = 0; i < N_REQ; i++) mq[i].delete();
                sb.delete();
                rr_m = 0;
            end else if (flush) begin
                for (int i = 0; i < N_REQ; i++) mq[i].delete();
                rr_m = 0;
            end else begin
                for (int i = 0; i < N_REQ; i++)
                    m_acc[i] = bus.req_valid[i] && (mq[i].size() < DEPTH);
                m_w = -1;
                for (int k = 0; k < N_REQ; k++) begin
                    m_j = (rr_m + k) % N_REQ;
                    if (m_w < 0 && mq[m_j].size() > 0) m_w = m_j;
                end
                if (m_w >= 0) begin
                    m_e = mq[m_w].pop_front();
                    if (m_e.pd != '0) sb.push_back(m_e);
                    rr_m = (m_w + 1) % N_REQ;
                end
                for (int i = 0; i < N_REQ; i++) begin
                    if (m_acc[i]) begin
                        m_e.pd   = bus.req_pd[i*PD_W +: PD_W];
                        m_e.data = bus.req_data[i*DATA_W +: DATA_W];
                        m_e.src  = SRC_W'(i);
                        mq[i].push_back(m_e);
                    end
                end
            end
        end
    end

    // Monitor: every cycle, compare ready and the writeback port with the model.
    logic [N_REQ-1:0] exp_rdy;
    wb_t              mon_e;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                check("rst_outputs", {bus.wb_en, bus.wb_pd, bus.wb_data, bus.wb_src, bus.req_ready}, 64'h0);
            end else begin
                for (int i = 0; i < N_REQ; i++)
                    exp_rdy[i] = !flush && (mq[i].size() < DEPTH);
                check("req_ready", bus.req_ready, exp_rdy);
                check("wb_en", bus.wb_en, sb.size() > 0);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    if (bus.wb_en) begin
                        check("wb_pd", bus.wb_pd, mon_e.pd);
                        check("wb_data", bus.wb_data, mon_e.data);
                        check("wb_src", bus.wb_src, mon_e.src);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = '0;
        flush = 1'b0;
    endtask

    task automatic set_req(input int i, input int pd, input logic [DATA_W-1:0] d);
        bus.req_valid[i] = 1'b1;
        bus.req_pd[i*PD_W +: PD_W] = PD_W'(pd);
        bus.req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_flush();
        bus.req_valid = '0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    logic [PD_W-1:0]  mem_tags [$];
    logic [N_REQ-1:0] rdy;
    int               alu_n;
    int               mem_n;
    bit               full_checked;

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.req_valid = '0;
        bus.req_pd = '0;
        bus.req_data = '0;
        repeat (3) cyc();
        reset = 1'b0;
        #1 check("ready_after_reset", bus.req_ready, 4'hF);

        // Single result: push in cycle 1, writeback in cycle 3.
        cyc();
        check("single_c1_en", bus.wb_en, 0);
        set_req(0, 5, 32'hDEADBEEF);
        cyc();
        idle();
        check("single_c2_en", bus.wb_en, 0);
        cyc();
        check("single_c3_en", bus.wb_en, 1);
        check("single_c3_pd", bus.wb_pd, 5);
        check("single_c3_data", bus.wb_data, 32'hDEADBEEF);
        check("single_c3_src", bus.wb_src, 0);
        cyc();
        check("single_c4_en", bus.wb_en, 0);

        // Round-robin fairness over two full rounds.
        do_flush();
        for (int i = 0; i < N_REQ; i++) set_req(i, 10 + i, 32'h100 + i);
        cyc();
        for (int i = 0; i < N_REQ; i++) set_req(i, 14 + i, 32'h200 + i);
        cyc();
        idle();
        for (int t = 0; t < 5 && !bus.wb_en; t++) cyc();
        check("rr_start", bus.wb_en, 1);
        for (int k = 0; k < 8; k++) begin
            check("rr_src", bus.wb_src, k % N_REQ);
            check("rr_pd", bus.wb_pd, 10 + k);
            cyc();
        end
        check("rr_done_en", bus.wb_en, 0);

        // Backpressure: mem sends three results while ALU keeps pushing.
        do_flush();
        alu_n = 0;
        mem_n = 0;
        full_checked = 0;
        mem_tags.delete();
        for (int c = 0; c < 12; c++) begin
            idle();
            set_req(0, 40 + alu_n, 32'h4000 + alu_n);
            if (mem_n < 3) set_req(2, 20 + mem_n, 32'h2000 + mem_n);
            #1 rdy = bus.req_ready;
            if (mem_n == 2 && !full_checked) begin
                check("bp_mem_full_ready", rdy[2], 0);
                full_checked = 1;
            end
            if (rdy[0]) alu_n++;
            if (bus.req_valid[2] && rdy[2]) begin
                if (mem_n == 2) check("bp_third_after_grant", mem_tags.size() > 0, 1);
                mem_n++;
            end
            cyc();
            if (bus.wb_en && bus.wb_src == 2) mem_tags.push_back(bus.wb_pd);
        end
        idle();
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (bus.wb_en && bus.wb_src == 2) mem_tags.push_back(bus.wb_pd);
        end
        check("bp_mem_count", mem_tags.size(), 3);
        for (int k = 0; k < mem_tags.size(); k++) check("bp_mem_order", mem_tags[k], 20 + k);

        // x0 suppression, branch alone.
        do_flush();
        set_req(1, 0, 32'h1234);
        cyc();
        set_req(1, 9, 32'h99);
        cyc();
        idle();
        check("x0_slot_en", bus.wb_en, 0);
        cyc();
        check("x0_next_en", bus.wb_en, 1);
        check("x0_next_pd", bus.wb_pd, 9);
        check("x0_next_src", bus.wb_src, 1);

        // x0 grant must move the round-robin pointer past the branch unit.
        do_flush();
        set_req(1, 0, 32'h1234);
        cyc();
        set_req(1, 9, 32'h99);
        set_req(0, 31, 32'h31);
        cyc();
        idle();
        check("x0rr_slot_en", bus.wb_en, 0);
        cyc();
        check("x0rr_first_src", bus.wb_src, 0);
        check("x0rr_first_pd", bus.wb_pd, 31);
        cyc();
        check("x0rr_second_src", bus.wb_src, 1);
        check("x0rr_second_pd", bus.wb_pd, 9);

        // Flush with six results buffered and muldiv offering a result.
        do_flush();
        for (int i = 0; i < N_REQ; i++) set_req(i, 50 + i, 32'h500 + i);
        cyc();
        idle();
        for (int i = 0; i < 3; i++) set_req(i, 54 + i, 32'h540 + i);
        cyc();
        idle();
        check("fl_inflight_en", bus.wb_en, 1);
        check("fl_inflight_pd", bus.wb_pd, 50);
        flush = 1'b1;
        set_req(3, 60, 32'h600);
        #1 check("fl_ready", bus.req_ready, 4'h0);
        cyc();
        idle();
        for (int t = 0; t < 3; t++) begin
            check("fl_quiet_en", bus.wb_en, 0);
            cyc();
        end
        set_req(3, 61, 32'h610);
        set_req(0, 62, 32'h620);
        cyc();
        idle();
        cyc();
        check("fl_restart_src0", bus.wb_src, 0);
        check("fl_restart_pd0", bus.wb_pd, 62);
        cyc();
        check("fl_restart_src3", bus.wb_src, 3);
        check("fl_restart_pd3", bus.wb_pd, 61);

        // Asynchronous reset in the middle of a burst.
        do_flush();
        for (int i = 0; i < N_REQ; i++) set_req(i, 70 + i, 32'h700 + i);
        cyc();
        for (int i = 0; i < N_REQ; i++) set_req(i, 74 + i, 32'h740 + i);
        cyc();
        idle();
        check("ar_pre_en", bus.wb_en, 1);
        check("ar_pre_pd", bus.wb_pd, 70);
        #2 reset = 1'b1;
        #1;
        check("ar_outputs_zero", {bus.wb_en, bus.wb_pd, bus.wb_data, bus.wb_src}, 64'h0);
        check("ar_ready_zero", bus.req_ready, 4'h0);
        cyc();
        cyc();
        reset = 1'b0;
        #1 check("ar_ready_release", bus.req_ready, 4'hF);
        for (int t = 0; t < 4; t++) begin
            cyc();
            check("ar_no_stale", bus.wb_en, 0);
        end

        // Randomized traffic with occasional flushes.
        for (int c = 0; c < 400; c++) begin
            idle();
            flush = ($urandom % 40) == 0;
            for (int i = 0; i < N_REQ; i++) begin
                if ($urandom % 3 != 0) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_pd[i*PD_W +: PD_W] = ($urandom % 8 == 0) ? '0 : PD_W'($urandom_range(127, 1));
                    bus.req_data[i*DATA_W +: DATA_W] = $urandom;
                end
            end
            cyc();
        end
        idle();
        repeat (10) cyc();
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Writeback arbiter sharing one physical-register-file write port and the matching result broadcast among several functional-unit result producers (ALU, branch, memory, mul/div). Each requester pushes completed results into a small private FIFO. A round-robin scheduler drains one buffered result per cycle onto a registered write/broadcast port, which drives one PRF write port and the reservation-station wakeup bus. Backpressure goes to the functional units through per-requester ready signals; a flush empties all in-flight results.

## Interface
- N_REQ, 4, number of requesters; index 0=ALU, 1=branch, 2=mem, 3=muldiv
- DEPTH, 2, entries per requester FIFO (power of two, ≥2)
- PD_W, 7, physical register tag width
- DATA_W, 32, result width

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous; drop all buffered results
- req_valid  in  N_REQ  result offered by requester i
- req_ready  out  N_REQ  requester i FIFO can accept this cycle
- req_pd  in  N_REQ*PD_W  destination tag; slice i = bits [i*PD_W +: PD_W]
- req_data  in  N_REQ*DATA_W  result data; slice i = bits [i*DATA_W +: DATA_W]
- wb_en  out  1  PRF write enable / broadcast valid (registered)
- wb_pd  out  PD_W  tag written/broadcast (registered)
- wb_data  out  DATA_W  data written (registered)
- wb_src  out  $clog2(N_REQ)  index of the requester that produced the current wb (registered)

## Operation
- Per requester: a circular FIFO with DEPTH entries, read/write pointers, and a count of width $clog2(DEPTH)+1.
- Push when req_valid[i] && req_ready[i]. req_ready[i] = !reset && !flush && count[i] < DEPTH. req_ready does not depend on the same-cycle pop, so there is no combinational path from arbitration to ready.
- A push and a pop to the same FIFO in one cycle is legal; count is unchanged.
- Pointers wrap modulo DEPTH.
- Arbitration is combinational over FIFO heads with count > 0. Search starts at rr_ptr and proceeds in ascending order modulo N_REQ; the first non-empty FIFO wins.
- The winner pops. Its head is registered into wb_pd/wb_data/wb_src. rr_ptr <= (winner+1) mod N_REQ.
- With no winner: wb_en <= 0, rr_ptr holds, and wb_pd/wb_data/wb_src hold their previous values.
- Results with pd == 0 are accepted, buffered, and arbitrated normally, but produce wb_en = 0 in their output cycle. They still consume the grant slot and advance rr_ptr, so x0 is never written or broadcast.
- flush:
  - All counts and pointers go to 0, rr_ptr goes to 0, and wb_en goes to 0 on the next edge.
  - No pop or push occurs in the flush cycle.
  - A wb_en already high during the flush cycle (from the previous grant) still completes; it is not retracted.
- reset (async) is the same as flush, plus every output register is cleared.

## Timing
- Reset values: wb_en=0, wb_pd=0, wb_data=0, wb_src=0, req_ready=0 while reset is high. After release, all FIFOs are empty, so req_ready is all-ones.
- Latency: push at edge t → entry visible at head during cycle t+1 → winning it in cycle t+1 gives wb_en=1 during cycle t+2. Minimum latency is 2 cycles, with no bypass.
- Throughput: one writeback per cycle total.
- Steady state with all requesters continuously non-empty: each requester is granted exactly once every N_REQ cycles.
- Starvation bound: a non-empty FIFO is granted within N_REQ cycles.
- Full boundary: when count == DEPTH, req_ready is 0 even if that FIFO pops in the same cycle. Ready rises the cycle after the pop.
- Empty boundary: no pop from an empty FIFO. When all FIFOs are empty, wb_en=0.
- Asserting req_valid while req_ready=0 has no effect. The requester holds its data until the handshake.

## Test plan
- Single result: after reset, ALU pushes pd=5, data=0xDEADBEEF at cycle 1. Required: wb_en=1, wb_pd=5, wb_data=0xDEADBEEF, wb_src=0 during cycle 3; wb_en=0 during cycles 1, 2 and 4.
- Round-robin fairness: all 4 requesters pre-filled with 2 entries each (pd 10–17). Required: wb_src sequence 0,1,2,3,0,1,2,3 on 8 consecutive cycles, then wb_en=0.
- Backpressure: mem pushes 3 results back-to-back while ALU keeps its FIFO full. Required:
  - req_ready[2] goes to 0 after 2 accepted pushes.
  - The third push completes only after mem's first grant.
  - All 3 tags appear in order.
- x0 suppression: branch pushes pd=0, data=0x1234, then pd=9. Required:
  - wb_en=0 in the pd=0 slot; wb_pd=9 with wb_en=1 the following cycle.
  - rr_ptr advanced past requester 1 for the pd=0 grant.
- Flush mid-operation: 6 entries buffered, flush asserted for 1 cycle while valid is high on requester 3. Required:
  - req_ready=0 in the flush cycle and the push is dropped.
  - At most the already-registered wb completes; no further wb_en.
  - Next grant order starts at requester 0.
- Async reset mid-burst: reset asserted between edges during wb_en=1. Required: all outputs 0 immediately; after release, req_ready=all-ones and no stale writeback appears.
